seq_fixedpoint_sin: RTL

- Multi-cycle CORDIC sine sequencer. One micro-rotation per clock, sharing a single rotation stage across N_ITER cycles instead of unrolling it.
- Trades throughput for area relative to the fully combinational sine unit.
- Sits between a fixed-point producer and consumer, with valid/ready handshakes on both sides.
- Input and output number formats are the same fixed-point formats the combinational sine unit uses.

---
 rtl/fixedpoint_sin_pkg.sv | 52 +++++
 rtl/comb_FixedPointZoom.sv | 59 +++++
 rtl/cordic_rot_step.sv | 28 ++
 rtl/seq_fixedpoint_sin.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/fixedpoint_sin_pkg.sv
// Shared types and constants for the sequential CORDIC sine unit.
// Angles and gains are stored in 4.28 and rescaled to the datapath format at elaboration.
package fixedpoint_sin_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RANGE = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WRI = 4;
    localparam int QF  = 28;

    localparam logic signed [31:0] HALFPI_Q28 = 32'sh1921fb54;
    localparam logic signed [31:0] XINIT_Q28  = 32'sh09b75555;

    function automatic logic signed [31:0] atan_q28(input logic [3:0] idx);
        case (idx)
            4'd0:    atan_q28 = 32'sh0c90fdaa;
            4'd1:    atan_q28 = 32'sh076b19c1;
            4'd2:    atan_q28 = 32'sh03eb6ebf;
            4'd3:    atan_q28 = 32'sh01fd5ba9;
            4'd4:    atan_q28 = 32'sh00ffaadd;
            4'd5:    atan_q28 = 32'sh007ff556;
            4'd6:    atan_q28 = 32'sh003ffeaa;
            4'd7:    atan_q28 = 32'sh001fffd5;
            4'd8:    atan_q28 = 32'sh000ffffb;
            4'd9:    atan_q28 = 32'sh0007ffff;
            4'd10:   atan_q28 = 32'sh00040000;
            4'd11:   atan_q28 = 32'sh00020000;
            4'd12:   atan_q28 = 32'sh00010000;
            4'd13:   atan_q28 = 32'sh00008000;
            4'd14:   atan_q28 = 32'sh00004000;
            4'd15:   atan_q28 = 32'sh00002000;
            default: atan_q28 = 32'sh00000000;
        endcase
    endfunction

    // Round-to-nearest rescale of a 4.28 value to wrf fractional bits.
    function automatic logic signed [31:0] q28_to_fix(input logic signed [31:0] v, input int wrf);
        logic signed [31:0] half;
        if (wrf < QF) begin
            half       = 32'sd1 <<< (QF - wrf - 1);
            q28_to_fix = (v + half) >>> (QF - wrf);
        end else begin
            half       = 32'sd0;
            q28_to_fix = v + half;
        end
    endfunction

endpackage

// File: rtl/comb_FixedPointZoom.sv
// Combinational fixed-point format converter: realigns the binary point with optional
// round-to-nearest, then saturates (or wraps) into the output integer range with flags.
module comb_FixedPointZoom #(
    parameter int WII   = 8,
    parameter int WIF   = 8,
    parameter int WOI   = 8,
    parameter int WOF   = 8,
    parameter int ROOF  = 1,
    parameter int ROUND = 1
) (
    input  logic [WII+WIF-1:0] in,
    output logic [WOI+WOF-1:0] out,
    output logic               upflow,
    output logic               downflow
);
    localparam int WIN   = WII + WIF;
    localparam int WOUT  = WOI + WOF;
    localparam int WW    = WIN + WOUT + 2;
    localparam int SH_UP = (WOF > WIF) ? (WOF - WIF) : 0;
    localparam int SH_DN = (WIF > WOF) ? (WIF - WOF) : 0;
    localparam int SH_H  = (SH_DN > 0) ? (SH_DN - 1) : 0;

    localparam logic signed [WW-1:0] ONE_W = {{(WW-1){1'b0}}, 1'b1};
    localparam logic signed [WW-1:0] HALF  = (ROUND != 0 && SH_DN > 0) ? (ONE_W <<< SH_H) : {WW{1'b0}};
    localparam logic signed [WW-1:0] MAXV  = {{(WW-WOUT+1){1'b0}}, {(WOUT-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV  = {{(WW-WOUT+1){1'b1}}, {(WOUT-1){1'b0}}};

    logic signed [WW-1:0] ext_s;
    logic signed [WW-1:0] scl_s;

    assign ext_s = {{(WW-WIN){in[WIN-1]}}, in};
    assign scl_s = ((ext_s <<< SH_UP) + HALF) >>> SH_DN;

    // Range check and saturation into the output word.
    always_comb begin
        upflow   = 1'b0;
        downflow = 1'b0;
        out      = scl_s[WOUT-1:0];
        if (scl_s > MAXV) begin
            upflow = 1'b1;
            if (ROOF != 0) begin
                out = MAXV[WOUT-1:0];
            end else begin
                out = scl_s[WOUT-1:0];
            end
        end else if (scl_s < MINV) begin
            downflow = 1'b1;
            if (ROOF != 0) begin
                out = MINV[WOUT-1:0];
            end else begin
                out = scl_s[WOUT-1:0];
            end
        end else begin
            upflow   = 1'b0;
            downflow = 1'b0;
        end
    end

endmodule

// File: rtl/cordic_rot_step.sv
// One CORDIC micro-rotation in rotation mode, steering z towards target.
module cordic_rot_step #(
    parameter int W = 16
) (
    input  logic signed [W-1:0] x_i,
    input  logic signed [W-1:0] y_i,
    input  logic signed [W-1:0] z_i,
    input  logic signed [W-1:0] target_i,
    input  logic        [3:0]   shift_i,
    input  logic signed [W-1:0] atan_i,
    output logic signed [W-1:0] x_o,
    output logic signed [W-1:0] y_o,
    output logic signed [W-1:0] z_o
);
    // Rotate towards the target; equality rotates negatively.
    always_comb begin
        if (target_i > z_i) begin
            x_o = x_i - (y_i >>> shift_i);
            y_o = y_i + (x_i >>> shift_i);
            z_o = z_i + atan_i;
        end else begin
            x_o = x_i + (y_i >>> shift_i);
            y_o = y_i - (x_i >>> shift_i);
            z_o = z_i - atan_i;
        end
    end

endmodule

// File: rtl/seq_fixedpoint_sin.sv
// Multi-cycle CORDIC sine: range check, N_ITER shared micro-rotations, then a held result
// behind a valid/ready handshake.
module seq_fixedpoint_sin
    import fixedpoint_sin_pkg::*;
#(
    parameter int WII    = 4,
    parameter int WIF    = 8,
    parameter int WOI    = 2,
    parameter int WOF    = 12,
    parameter int ROOF   = 1,
    parameter int ROUND  = 1,
    parameter int N_ITER = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [WII+WIF-1:0]   in,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [WOI+WOF-1:0]   out,
    output logic                 upflow,
    output logic                 downflow
);
    localparam int WRF = (WOF > WIF) ? WOF : WIF;
    localparam int WR  = WRI + WRF;

    localparam logic signed [WR-1:0] HALFPI_R = WR'(q28_to_fix(HALFPI_Q28, WRF));
    localparam logic signed [WR-1:0] XINIT_R  = WR'(q28_to_fix(XINIT_Q28, WRF));
    localparam logic signed [WR-1:0] ONE_R    = {{(WRI-1){1'b0}}, 1'b1, {WRF{1'b0}}};
    localparam logic        [3:0]    CNT_LAST = 4'(N_ITER - 1);

    state_t state_q, state_d;
    logic signed [WR-1:0] x_q, x_d, y_q, y_d, z_q, z_d, tgt_q, tgt_d;
    logic        [3:0]    cnt_q, cnt_d;
    logic [WOI+WOF-1:0]   out_q, out_d;
    logic                 up_q, up_d, dn_q, dn_d, o_valid_q, o_valid_d;

    logic [WR-1:0]        tgt_conv_s;
    logic                 unused_in_up_s, unused_in_dn_s;
    logic signed [WR-1:0] atan_s, x_n_s, y_n_s, z_n_s;
    logic [WOI+WOF-1:0]   res_s;
    logic                 res_up_s, res_dn_s, rng_up_s, rng_dn_s, done_entry_s;

    comb_FixedPointZoom #(
        .WII(WII), .WIF(WIF), .WOI(WRI), .WOF(WRF), .ROOF(0), .ROUND(1)
    ) u_in_zoom (
        .in(in), .out(tgt_conv_s), .upflow(unused_in_up_s), .downflow(unused_in_dn_s)
    );

    cordic_rot_step #(.W(WR)) u_step (
        .x_i(x_q), .y_i(y_q), .z_i(z_q), .target_i(tgt_q), .shift_i(cnt_q), .atan_i(atan_s),
        .x_o(x_n_s), .y_o(y_n_s), .z_o(z_n_s)
    );

    comb_FixedPointZoom #(
        .WII(WRI), .WIF(WRF), .WOI(WOI), .WOF(WOF), .ROOF(ROOF), .ROUND(ROUND)
    ) u_out_zoom (
        .in(y_d), .out(res_s), .upflow(res_up_s), .downflow(res_dn_s)
    );

    // Arctangent ROM indexed by the iteration counter.
    always_comb begin
        atan_s = WR'(q28_to_fix(atan_q28(cnt_q), WRF));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_valid) state_d = RANGE;
                else         state_d = IDLE;
            end
            RANGE: begin
                if (tgt_q[WR-1] || (tgt_q > HALFPI_R)) state_d = DONE;
                else                                   state_d = ITER;
            end
            ITER: begin
                if (cnt_q == CNT_LAST) state_d = DONE;
                else                   state_d = ITER;
            end
            DONE: begin
                if (o_ready) state_d = IDLE;
                else         state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values; out-of-range results are forced into y so they share the output path.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        tgt_d    = tgt_q;
        cnt_d    = cnt_q;
        rng_up_s = 1'b0;
        rng_dn_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_valid) tgt_d = tgt_conv_s;
                else         tgt_d = tgt_q;
            end
            RANGE: begin
                if (tgt_q[WR-1]) begin
                    y_d      = {WR{1'b0}};
                    rng_dn_s = 1'b1;
                end else if (tgt_q > HALFPI_R) begin
                    y_d      = ONE_R;
                    rng_up_s = 1'b1;
                end else begin
                    x_d   = XINIT_R;
                    y_d   = {WR{1'b0}};
                    z_d   = {WR{1'b0}};
                    cnt_d = 4'd0;
                end
            end
            ITER: begin
                x_d   = x_n_s;
                y_d   = y_n_s;
                z_d   = z_n_s;
                cnt_d = cnt_q + 4'd1;
            end
            DONE:    cnt_d = cnt_q;
            default: cnt_d = cnt_q;
        endcase
    end

    // Output outputs: result captured once on entry to DONE and held until consumed.
    always_comb begin
        done_entry_s = (state_d == DONE) && (state_q != DONE);
        o_valid_d    = (state_d == DONE);
        if (done_entry_s) begin
            out_d = res_s;
            up_d  = res_up_s | rng_up_s;
            dn_d  = res_dn_s | rng_dn_s;
        end else begin
            out_d = out_q;
            up_d  = up_q;
            dn_d  = dn_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= {WR{1'b0}};
            y_q       <= {WR{1'b0}};
            z_q       <= {WR{1'b0}};
            tgt_q     <= {WR{1'b0}};
            cnt_q     <= 4'd0;
            out_q     <= {(WOI+WOF){1'b0}};
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            o_valid_q <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            z_q       <= z_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            o_valid_q <= o_valid_d;
        end
    end

    assign i_ready  = (state_q == IDLE);
    assign o_valid  = o_valid_q;
    assign out      = out_q;
    assign upflow   = up_q;
    assign downflow = dn_q;

endmodule
